// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: drives the instruction-memory address from a
// start pulse until halt, PC overflow or watchdog expiry, and reports run stats.
module fetch_sequencer #(
    parameter int unsigned PC_BITS    = 12,
    parameter int unsigned CNT_BITS   = 16,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_BITS-1:0]  start_addr,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_BITS-1:0]  branch_target,
    input  logic                halt,
    output logic [PC_BITS-1:0]  pc,
    output logic                fetch_valid,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic [CNT_BITS-1:0] icount,
    output logic [CNT_BITS-1:0] cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]          ERR_OK       = 2'b00;
    localparam logic [1:0]          ERR_OVERFLOW = 2'b01;
    localparam logic [1:0]          ERR_WATCHDOG = 2'b10;
    localparam logic [PC_BITS-1:0]  PC_LAST      = '1;
    localparam logic [CNT_BITS-1:0] CNT_SAT      = '1;
    // Cycle count at which the current RUN cycle is the last one allowed.
    localparam logic [CNT_BITS-1:0] WD_LAST      = CNT_BITS'(MAX_CYCLES - 1);

    state_t state;

    // State flags decoded straight from the registered state.
    assign busy        = (state == RUN);
    assign fetch_valid = (state == RUN);

    // Sequencer FSM with all reported values held in registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= '0;
            done   <= 1'b0;
            err    <= ERR_OK;
            icount <= '0;
            cycles <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        pc     <= start_addr;
                        done   <= 1'b0;
                        err    <= ERR_OK;
                        icount <= '0;
                        cycles <= '0;
                    end
                end

                RUN: begin
                    if (cycles != CNT_SAT) begin
                        cycles <= cycles + CNT_BITS'(1);
                    end

                    if (halt) begin
                        // The halt instruction itself retires.
                        state  <= DONE;
                        done   <= 1'b1;
                        err    <= ERR_OK;
                        icount <= icount + CNT_BITS'(1);
                    end else if (cycles == WD_LAST) begin
                        // A stalled instruction on the final cycle does not retire.
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= ERR_WATCHDOG;
                        if (!stall) begin
                            icount <= icount + CNT_BITS'(1);
                        end
                    end else if (branch_taken) begin
                        // A redirect wins over a stall.
                        pc     <= branch_target;
                        icount <= icount + CNT_BITS'(1);
                    end else if (stall) begin
                        pc     <= pc;
                    end else if (pc == PC_LAST) begin
                        // Stop at the top of memory instead of wrapping to 0.
                        state  <= DONE;
                        done   <= 1'b1;
                        err    <= ERR_OVERFLOW;
                        icount <= icount + CNT_BITS'(1);
                    end else begin
                        pc     <= pc + PC_BITS'(1);
                        icount <= icount + CNT_BITS'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench for fetch_sequencer with a behavioural reference model,
// plus directed scenarios pinned by hand-computed values.
module tb_fetch_sequencer;

    localparam int MAXC    = 8;
    localparam int PC_TOP  = 4095;
    localparam int CNT_TOP = 65535;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] start_addr;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        halt;
    logic [11:0] pc;
    logic        fetch_valid;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [15:0] icount;
    logic [15:0] cycles;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .PC_BITS   (12),
        .CNT_BITS  (16),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .icount       (icount),
        .cycles       (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a sequence of cycles; each cycle either
    // finishes the run with a reason or moves/keeps the address.
    bit m_valid = 1'b0;
    bit m_running = 1'b0;
    bit m_finished = 1'b0;
    int m_pc = 0;
    int m_err = 0;
    int m_ic = 0;
    int m_cy = 0;
    bit m_last_allowed;

    always @(posedge clk) begin
        if (reset) begin
            m_valid    = 1'b1;
            m_running  = 1'b0;
            m_finished = 1'b0;
            m_pc = 0; m_err = 0; m_ic = 0; m_cy = 0;
        end else if (m_running) begin
            m_last_allowed = (m_cy + 1 == MAXC);
            if (m_cy < CNT_TOP) m_cy = m_cy + 1;
            if (halt) begin
                m_running = 1'b0; m_finished = 1'b1; m_err = 0; m_ic = m_ic + 1;
            end else if (m_last_allowed) begin
                m_running = 1'b0; m_finished = 1'b1; m_err = 2;
                if (!stall) m_ic = m_ic + 1;
            end else if (branch_taken) begin
                m_pc = int'(branch_target); m_ic = m_ic + 1;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (m_pc == PC_TOP) begin
                m_running = 1'b0; m_finished = 1'b1; m_err = 1; m_ic = m_ic + 1;
            end else begin
                m_pc = m_pc + 1; m_ic = m_ic + 1;
            end
        end else if (start) begin
            m_running = 1'b1; m_finished = 1'b0;
            m_pc = int'(start_addr); m_err = 0; m_ic = 0; m_cy = 0;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model pc", int'(pc), m_pc);
            chk("model busy", int'(busy), int'(m_running));
            chk("model fetch_valid", int'(fetch_valid), int'(m_running));
            chk("model done", int'(done), int'(m_finished));
            chk("model err", int'(err), m_err);
            chk("model icount", int'(icount), m_ic);
            chk("model cycles", int'(cycles), m_cy);
            chk("icount<=cycles", int'(icount <= cycles), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic go(input logic [11:0] addr);
        start = 1'b1; start_addr = addr;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_addr = '0; branch_target = '0;
        quiet();
        tick();
        tick();
        chk("reset pc", int'(pc), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset icount", int'(icount), 0);
        reset = 1'b0;

        // Straight-line fetch.
        go(12'h010);
        chk("t1 first pc", int'(pc), 'h010);
        chk("t1 fetch_valid", int'(fetch_valid), 1);
        repeat (4) tick();
        chk("t1 pc", int'(pc), 'h014);
        chk("t1 icount", int'(icount), 4);
        chk("t1 cycles", int'(cycles), 4);

        // Stall then branch overriding stall.
        do_reset();
        go(12'h020);
        stall = 1'b1;
        tick(); tick();
        chk("t2 stall pc", int'(pc), 'h020);
        chk("t2 stall icount", int'(icount), 0);
        branch_taken = 1'b1; branch_target = 12'h200;
        tick();
        quiet();
        chk("t2 branch pc", int'(pc), 'h200);
        chk("t2 branch icount", int'(icount), 1);

        // Halt, then restart from DONE.
        do_reset();
        go(12'h000);
        repeat (5) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3 done", int'(done), 1);
        chk("t3 err", int'(err), 0);
        chk("t3 pc", int'(pc), 'h005);
        chk("t3 icount", int'(icount), 6);
        tick();
        chk("t3 frozen icount", int'(icount), 6);
        go(12'h100);
        chk("t3 restart pc", int'(pc), 'h100);
        chk("t3 restart icount", int'(icount), 0);
        chk("t3 restart done", int'(done), 0);

        // PC overflow stops at the top of memory.
        do_reset();
        go(12'hFFE);
        tick();
        chk("t4 pc top", int'(pc), 'hFFF);
        tick();
        chk("t4 done", int'(done), 1);
        chk("t4 err", int'(err), 1);
        chk("t4 pc frozen", int'(pc), 'hFFF);
        chk("t4 icount", int'(icount), 2);

        // Watchdog with a permanent stall.
        do_reset();
        go(12'h123);
        stall = 1'b1;
        repeat (7) tick();
        chk("t5 still busy", int'(busy), 1);
        tick();
        quiet();
        chk("t5 done", int'(done), 1);
        chk("t5 err", int'(err), 2);
        chk("t5 cycles", int'(cycles), 8);
        chk("t5 icount", int'(icount), 0);
        chk("t5 pc", int'(pc), 'h123);

        // Reset mid-run; start ignored while running.
        do_reset();
        go(12'h030);
        repeat (3) tick();
        chk("t6 pc", int'(pc), 'h033);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 reset pc", int'(pc), 0);
        chk("t6 reset busy", int'(busy), 0);
        chk("t6 reset done", int'(done), 0);
        go(12'h040);
        repeat (2) tick();
        start = 1'b1; start_addr = 12'h700;
        tick();
        start = 1'b0;
        chk("t6 ignored start pc", int'(pc), 'h043);
        chk("t6 ignored start icount", int'(icount), 3);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            start         = ($urandom_range(0, 7) == 0);
            start_addr    = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7))
                                                        : 12'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 12'(12'hFFA + $urandom_range(0, 5))
                                                        : 12'($urandom);
            halt          = ($urandom_range(0, 19) == 0);
            tick();
        end
        quiet();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
